scoreboard_entry_ctrl: RTL and testbench
========================================

Name: scoreboard_entry_ctrl

Overview:
Sequences the high-score name-entry screen: owns the cursor position and the three 5-bit name characters that drive the scoreboard pixel generator (input_pos, player_name). It steps an edit FSM from debounced button pulses, blinks the cursor, and commits the name plus the latched score to the score store through a valid/ready handshake. Sits between the button one-pulse logic and the scoreboard pixel generator / score store.

Parameters:
CHAR_MAX, 25, highest character code (0 = 'A' .. 25 = 'Z'); codes wrap within 0..CHAR_MAX
INIT_CHAR, 0, value loaded into all three characters on start
BLINK_CYCLES, 12500000, clk cycles per half-period of the cursor blink
SCORE_W, 14, width of the score being recorded

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin name entry; sampled only in IDLE
score_in  in  SCORE_W  score to record; latched on accepted start
btn_left  in  1  one-cycle pulse, move cursor left
btn_right  in  1  one-cycle pulse, move cursor right
btn_up  in  1  one-cycle pulse, increment character at cursor
btn_down  in  1  one-cycle pulse, decrement character at cursor
btn_enter  in  1  one-cycle pulse, advance / confirm
input_pos  out  2  cursor: 0..2 = character slot, 3 = whole-name confirm box
player_name  out  15  {ch0, ch1, ch2}, 5 bits each, ch0 in MSBs
cursor_on  out  1  blink phase; pixel path gates the cursor box with it
busy  out  1  high in EDIT and COMMIT
commit_valid  out  1  request to the score store
commit_ready  in  1  score store accepts when commit_valid && commit_ready
commit_name  out  15  equals player_name, stable while commit_valid
commit_score  out  SCORE_W  latched score, stable while commit_valid
done  out  1  one-cycle pulse after the handshake completes

Behaviour:
- Reset (async, any state): state=IDLE, input_pos=0, all chars=INIT_CHAR, score latch=0, cursor_on=1, blink counter=0, busy=0, commit_valid=0, done=0.
- States: IDLE, EDIT, COMMIT, DONE.
- IDLE: start -> EDIT next cycle. Same edge loads chars=INIT_CHAR, input_pos=0, latches score_in, clears blink counter, cursor_on=1. Buttons ignored.
- EDIT: at most one action per cycle. Priority enter > left > right > up > down; lower-priority pulses in the same cycle are dropped.
  - enter at pos 0..2: pos+1. Enter at pos 3: go to COMMIT.
  - left: pos-1, wrapping 0->3. right: pos+1, wrapping 3->0.
  - up at pos 0..2: char+1, with CHAR_MAX->0. down: char-1, with 0->CHAR_MAX. Up/down at pos 3 ignored.
  - Any accepted action restarts the blink counter and forces cursor_on=1 on the next cycle.
  - start ignored.
- Blink: in EDIT the counter runs 0..BLINK_CYCLES-1. At the terminal count it wraps to 0 and toggles cursor_on. Outside EDIT, cursor_on=1 and the counter is held at 0.
- COMMIT: commit_valid=1 from the first COMMIT cycle. commit_name and commit_score are registered and stable until accepted. Buttons and start ignored. When commit_valid && commit_ready at a clock edge -> DONE; commit_valid drops the next cycle. commit_ready asserted before COMMIT has no effect.
- DONE: done=1 for exactly one cycle, then IDLE. input_pos and player_name retain the committed values until the next start.
- Latency:
  - start -> busy: 1 cycle.
  - Button -> updated input_pos/player_name: 1 cycle (registered outputs).
  - enter@pos3 -> commit_valid: 1 cycle.
  - Handshake -> done: 1 cycle.
- Reset mid-COMMIT abandons the write; commit_valid drops asynchronously.

Decomposition:
- Shared package scoreboard_pkg:
  - state enum (IDLE, EDIT, COMMIT, DONE)
  - POS_CONFIRM=2'd3
  - CHAR_W=5, NAME_W=15
  - letter constants for 'A'=0 and 'Z'=25, shared with the pixel generator's text offset of 10
- One sub-module, entry_blink_timer: the counter plus the cursor_on toggle, with a restart input and an enable input.

Test Plan:
- Reset, then start with score_in=1234 -> busy=1 after 1 cycle, input_pos=0, player_name=15'h0000, cursor_on=1.
- In EDIT, down at pos0 -> ch0=25. Then up twice -> ch0=1. Then right and up -> input_pos=1, player_name=15'h0420.
- At pos0, left -> input_pos=3. Then up at pos3 -> player_name unchanged. Then right -> input_pos=0.
- enter and up pulsed in the same cycle at pos1 -> input_pos=2, ch1 unchanged.
- enter at pos3 with commit_ready low for 5 cycles -> commit_valid held with commit_name=player_name and commit_score=1234 throughout. Raise commit_ready -> commit_valid drops 1 cycle later, done pulses once, state returns to IDLE.
- BLINK_CYCLES=4 with no buttons -> cursor_on toggles every 4 cycles. A button pulse -> cursor_on=1 and the count restarts. Async rst asserted mid-COMMIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the high-score name-entry screen and the
// scoreboard pixel generator that renders its characters.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int CHAR_W = 5;
    localparam int NAME_W = 15;

    localparam logic [1:0] POS_CONFIRM = 2'd3;

    // Letter codes; the pixel generator adds TEXT_OFFSET to reach its glyph table.
    localparam logic [CHAR_W-1:0] LETTER_A    = 5'd0;
    localparam logic [CHAR_W-1:0] LETTER_Z    = 5'd25;
    localparam int                TEXT_OFFSET = 10;

    function automatic logic [CHAR_W-1:0] char_step(
        input logic [CHAR_W-1:0] ch,
        input logic              inc,
        input logic [CHAR_W-1:0] max_code
    );
        logic [CHAR_W-1:0] nxt;
        if (inc) begin
            nxt = (ch == max_code) ? 5'd0 : ch + 5'd1;
        end else begin
            nxt = (ch == 5'd0) ? max_code : ch - 5'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/entry_blink_timer.sv
// Cursor blink generator: free-running half-period counter that toggles
// cursor_on while enabled, and parks with the cursor visible otherwise.
module entry_blink_timer #(
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_cursor_on
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_on;

    // Half-period counter and blink phase; restart or disable shows the cursor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
            r_on  <= 1'b1;
        end else if (i_restart || !i_enable) begin
            r_cnt <= {CNT_W{1'b0}};
            r_on  <= 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= {CNT_W{1'b0}};
            r_on  <= ~r_on;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cursor_on = r_on;

endmodule

// File: rtl/scoreboard_entry_ctrl.sv
// High-score name-entry sequencer: edits three letters with the buttons,
// then hands name and latched score to the score store via valid/ready.
module scoreboard_entry_ctrl
    import scoreboard_pkg::*;
#(
    parameter int CHAR_MAX     = 25,
    parameter int INIT_CHAR    = 0,
    parameter int BLINK_CYCLES = 12500000,
    parameter int SCORE_W      = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_enter,
    output logic [1:0]         input_pos,
    output logic [NAME_W-1:0]  player_name,
    output logic               cursor_on,
    output logic               busy,
    output logic               commit_valid,
    input  logic               commit_ready,
    output logic [NAME_W-1:0]  commit_name,
    output logic [SCORE_W-1:0] commit_score,
    output logic               done
);

    localparam logic [CHAR_W-1:0] CH_MAX  = CHAR_W'(CHAR_MAX);
    localparam logic [CHAR_W-1:0] CH_INIT = CHAR_W'(INIT_CHAR);

    state_e             r_state;
    logic [1:0]         r_pos;
    logic [CHAR_W-1:0]  r_ch [3];
    logic [SCORE_W-1:0] r_score;

    state_e             w_state_nxt;
    logic [1:0]         w_pos_nxt;
    logic [CHAR_W-1:0]  w_ch_nxt [3];
    logic               w_start_acc;
    logic               w_action;
    logic               w_char_edit;
    logic               w_char_inc;

    // Next-state and edit datapath; one action per cycle, enter > left > right > up > down.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_ch_nxt    = r_ch;
        w_start_acc = 1'b0;
        w_action    = 1'b0;
        w_char_edit = 1'b0;
        w_char_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_EDIT;
                    w_pos_nxt   = 2'd0;
                    w_start_acc = 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        w_ch_nxt[i] = CH_INIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EDIT: begin
                if (btn_enter) begin
                    w_action = 1'b1;
                    if (r_pos == POS_CONFIRM) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_pos_nxt = r_pos + 2'd1;
                    end
                end else if (btn_left) begin
                    w_action  = 1'b1;
                    w_pos_nxt = r_pos - 2'd1;
                end else if (btn_right) begin
                    w_action  = 1'b1;
                    w_pos_nxt = r_pos + 2'd1;
                end else if (btn_up && (r_pos != POS_CONFIRM)) begin
                    w_action    = 1'b1;
                    w_char_edit = 1'b1;
                    w_char_inc  = 1'b1;
                end else if (btn_down && (r_pos != POS_CONFIRM)) begin
                    w_action    = 1'b1;
                    w_char_edit = 1'b1;
                end else begin
                    w_action = 1'b0;
                end
                for (int i = 0; i < 3; i++) begin
                    if (w_char_edit && (r_pos == 2'(i))) begin
                        w_ch_nxt[i] = char_step(r_ch[i], w_char_inc, CH_MAX);
                    end else begin
                        w_ch_nxt[i] = r_ch[i];
                    end
                end
            end
            ST_COMMIT: begin
                if (commit_ready) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, cursor, name characters and the score latched at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pos   <= 2'd0;
            r_score <= {SCORE_W{1'b0}};
            for (int i = 0; i < 3; i++) begin
                r_ch[i] <= CH_INIT;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            r_ch    <= w_ch_nxt;
            if (w_start_acc) begin
                r_score <= score_in;
            end else begin
                r_score <= r_score;
            end
        end
    end

    entry_blink_timer #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (r_state == ST_EDIT),
        .i_restart  (w_action | w_start_acc),
        .o_cursor_on(cursor_on)
    );

    // Name and score hold still through COMMIT because edits are ignored there.
    assign input_pos    = r_pos;
    assign player_name  = {r_ch[0], r_ch[1], r_ch[2]};
    assign busy         = (r_state == ST_EDIT) || (r_state == ST_COMMIT);
    assign commit_valid = (r_state == ST_COMMIT);
    assign done         = (r_state == ST_DONE);
    assign commit_name  = player_name;
    assign commit_score = r_score;

endmodule

// File: tb/tb_scoreboard_entry_ctrl.sv
// Self-checking bench for scoreboard_entry_ctrl: edit vectors from a table via
// a scoreboard queue, plus hand sequences for commit, blink and async reset.
module tb_scoreboard_entry_ctrl;

    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] score_in;
    logic          btn_left, btn_right, btn_up, btn_down, btn_enter;
    logic [1:0]    input_pos;
    logic [14:0]   player_name;
    logic          cursor_on;
    logic          busy;
    logic          commit_valid;
    logic          commit_ready;
    logic [14:0]   commit_name;
    logic [SW-1:0] commit_score;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scoreboard_entry_ctrl #(
        .CHAR_MAX(25), .INIT_CHAR(0), .BLINK_CYCLES(4), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .score_in(score_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_enter(btn_enter),
        .input_pos(input_pos), .player_name(player_name), .cursor_on(cursor_on),
        .busy(busy), .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_name(commit_name), .commit_score(commit_score), .done(done)
    );

    // Button vector order: {enter, left, right, up, down}
    localparam logic [4:0] B_0  = 5'b00000;
    localparam logic [4:0] B_EN = 5'b10000;
    localparam logic [4:0] B_L  = 5'b01000;
    localparam logic [4:0] B_R  = 5'b00100;
    localparam logic [4:0] B_U  = 5'b00010;
    localparam logic [4:0] B_D  = 5'b00001;

    typedef struct {
        logic        st;
        logic [4:0]  btn;
        logic [1:0]  pos;
        logic [14:0] name;
        logic        cur;
    } vec_t;

    typedef struct {
        logic [1:0]  pos;
        logic [14:0] name;
        logic        cur;
    } exp_t;

    vec_t vecs [18];
    exp_t sbq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic st, input logic [4:0] b);
        start = st;
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = B_0;
    endtask

    initial begin
        exp_t e;

        vecs[0]  = '{1'b0, B_D,       2'd0, 15'h6400, 1'b1};
        vecs[1]  = '{1'b0, B_U,       2'd0, 15'h0000, 1'b1};
        vecs[2]  = '{1'b0, B_U,       2'd0, 15'h0400, 1'b1};
        vecs[3]  = '{1'b0, B_R,       2'd1, 15'h0400, 1'b1};
        vecs[4]  = '{1'b0, B_U,       2'd1, 15'h0420, 1'b1};
        vecs[5]  = '{1'b0, B_L,       2'd0, 15'h0420, 1'b1};
        vecs[6]  = '{1'b0, B_L,       2'd3, 15'h0420, 1'b1};
        vecs[7]  = '{1'b0, B_U,       2'd3, 15'h0420, 1'b1};
        vecs[8]  = '{1'b1, B_D,       2'd3, 15'h0420, 1'b1};
        vecs[9]  = '{1'b0, B_R,       2'd0, 15'h0420, 1'b1};
        vecs[10] = '{1'b0, B_R,       2'd1, 15'h0420, 1'b1};
        vecs[11] = '{1'b0, B_EN|B_U,  2'd2, 15'h0420, 1'b1};
        vecs[12] = '{1'b0, B_D,       2'd2, 15'h0439, 1'b1};
        vecs[13] = '{1'b0, B_L|B_R,   2'd1, 15'h0439, 1'b1};
        vecs[14] = '{1'b0, B_R|B_U,   2'd2, 15'h0439, 1'b1};
        vecs[15] = '{1'b0, B_U|B_D,   2'd2, 15'h0420, 1'b1};
        vecs[16] = '{1'b0, B_EN,      2'd3, 15'h0420, 1'b1};
        vecs[17] = '{1'b0, B_0,       2'd3, 15'h0420, 1'b1};

        rst = 1'b1; start = 1'b0; score_in = '0; commit_ready = 1'b0;
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = B_0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos", 32'(input_pos), 32'd0);
        chk("rst_name", 32'(player_name), 32'h0);
        chk("rst_cursor", 32'(cursor_on), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(commit_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // IDLE ignores buttons and an early commit_ready
        commit_ready = 1'b1;
        apply(1'b0, B_U);
        chk("idle_name", 32'(player_name), 32'h0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(commit_valid), 32'd0);
        commit_ready = 1'b0;

        score_in = 14'd1234;
        apply(1'b1, B_0);
        score_in = 14'd999;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pos", 32'(input_pos), 32'd0);
        chk("start_name", 32'(player_name), 32'h0);
        chk("start_cursor", 32'(cursor_on), 32'd1);

        for (int i = 0; i < 18; i++) begin
            sbq.push_back('{vecs[i].pos, vecs[i].name, vecs[i].cur});
            apply(vecs[i].st, vecs[i].btn);
            if (sbq.size() == 0) begin
                chk($sformatf("row%0d_queue", i), 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("row%0d_pos", i), 32'(input_pos), 32'(e.pos));
                chk($sformatf("row%0d_name", i), 32'(player_name), 32'(e.name));
                chk($sformatf("row%0d_cursor", i), 32'(cursor_on), 32'(e.cur));
                chk($sformatf("row%0d_busy", i), 32'(busy), 32'd1);
            end
        end

        // Commit with the store stalling for five cycles
        apply(1'b0, B_EN);
        chk("cm_valid", 32'(commit_valid), 32'd1);
        chk("cm_name", 32'(commit_name), 32'h0420);
        chk("cm_score", 32'(commit_score), 32'd1234);
        chk("cm_done", 32'(done), 32'd0);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, (k == 2) ? (B_U | B_L) : B_0);
            chk($sformatf("stall%0d_valid", k), 32'(commit_valid), 32'd1);
            chk($sformatf("stall%0d_name", k), 32'(commit_name), 32'h0420);
            chk($sformatf("stall%0d_score", k), 32'(commit_score), 32'd1234);
            chk($sformatf("stall%0d_pos", k), 32'(input_pos), 32'd3);
            chk($sformatf("stall%0d_busy", k), 32'(busy), 32'd1);
        end
        commit_ready = 1'b1;
        apply(1'b0, B_0);
        commit_ready = 1'b0;
        chk("hs_valid", 32'(commit_valid), 32'd0);
        chk("hs_done", 32'(done), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
        apply(1'b0, B_0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_pos", 32'(input_pos), 32'd3);
        chk("post_name", 32'(player_name), 32'h0420);

        // Blink: half-period of 4 cycles, restarted by an accepted button
        score_in = 14'd77;
        apply(1'b1, B_0);
        chk("s2_name", 32'(player_name), 32'h0);
        chk("s2_pos", 32'(input_pos), 32'd0);
        for (int k = 1; k <= 13; k++) begin
            apply(1'b0, B_0);
            chk($sformatf("blink%0d", k), 32'(cursor_on), 32'(((k / 4) % 2) == 0));
        end
        apply(1'b0, B_R);
        chk("blink_restart", 32'(cursor_on), 32'd1);
        chk("blink_pos", 32'(input_pos), 32'd1);
        for (int j = 1; j <= 5; j++) begin
            apply(1'b0, B_0);
            chk($sformatf("reblink%0d", j), 32'(cursor_on), 32'(j < 4));
        end

        // Async reset while a commit is pending
        apply(1'b0, B_U);
        chk("ar_name", 32'(player_name), 32'h0020);
        apply(1'b0, B_R);
        apply(1'b0, B_R);
        apply(1'b0, B_EN);
        chk("ar_valid_pre", 32'(commit_valid), 32'd1);
        chk("ar_score_pre", 32'(commit_score), 32'd77);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(commit_valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_pos", 32'(input_pos), 32'd0);
        chk("ar_name0", 32'(player_name), 32'h0);
        chk("ar_cursor", 32'(cursor_on), 32'd1);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_score", 32'(commit_score), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, B_0);
        chk("ar_idle_busy", 32'(busy), 32'd0);
        chk("ar_idle_valid", 32'(commit_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
